// File: rtl/help_pkg.sv
// Shared constants and state encoding for the help overlay renderer.
// Image geometry, colour key and reveal FSM states.
package help_pkg;

    localparam int IMG_W = 280;
    localparam int IMG_H = 200;
    localparam int X0    = 180;
    localparam int Y0    = 140;
    localparam int REV_W = 8;

    localparam logic [11:0] KEY_CLR = 12'h0F0;

    typedef enum logic [1:0] {
        ST_HIDDEN  = 2'd0,
        ST_OPENING = 2'd1,
        ST_SHOWN   = 2'd2,
        ST_CLOSING = 2'd3
    } help_state_e;

endpackage

// File: rtl/help_reveal_fsm.sv
// Help overlay reveal controller: open/close state and the number
// of image rows currently revealed, stepped once per frame.
module help_reveal_fsm
    import help_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick_i,
    input  logic             help_toggle_i,
    output logic [REV_W-1:0] reveal_o,
    output logic             help_active_o
);

    localparam logic [REV_W:0] STEP_W = (REV_W+1)'(STEP);
    localparam logic [REV_W:0] H_W    = (REV_W+1)'(IMG_H);

    help_state_e      state_q, state_d;
    logic [REV_W-1:0] reveal_q, reveal_d;
    logic             active_q, active_d;
    logic [REV_W:0]   sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HIDDEN;
            reveal_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reveal_q <= reveal_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        reveal_d = reveal_q;
        sum      = {1'b0, reveal_q} + STEP_W;
        // A toggle wins over a coincident tick; reveal holds that cycle.
        if (help_toggle_i) begin
            unique case (state_q)
                ST_HIDDEN:  state_d = ST_OPENING;
                ST_OPENING: state_d = ST_CLOSING;
                ST_SHOWN:   state_d = ST_CLOSING;
                ST_CLOSING: state_d = ST_OPENING;
                default:    state_d = ST_HIDDEN;
            endcase
        end else if (frame_tick_i) begin
            if (state_q == ST_OPENING) begin
                if (sum >= H_W) begin
                    reveal_d = REV_W'(IMG_H);
                    state_d  = ST_SHOWN;
                end else begin
                    reveal_d = sum[REV_W-1:0];
                end
            end else if (state_q == ST_CLOSING) begin
                if ({1'b0, reveal_q} <= STEP_W) begin
                    reveal_d = '0;
                    state_d  = ST_HIDDEN;
                end else begin
                    reveal_d = reveal_q - STEP_W[REV_W-1:0];
                end
            end
        end
    end

    always_comb begin
        active_d = (state_d != ST_HIDDEN);
    end

    assign reveal_o      = reveal_q;
    assign help_active_o = active_q;

endmodule

// File: rtl/help_overlay_render.sv
// Help picture overlay: window test, ROM addressing, 3-stage aligned
// pipeline and colour-keyed composite over the game background.
module help_overlay_render
    import help_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  col,
    input  logic [8:0]  row,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        help_toggle,
    input  logic [11:0] bg_clr,
    output logic [9:0]  img_x,
    output logic [8:0]  img_y,
    input  logic [11:0] img_clr,
    output logic [11:0] vga_rgb,
    output logic        help_active
);

    logic [REV_W-1:0] reveal;

    help_reveal_fsm #(.STEP(STEP)) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .frame_tick_i  (frame_tick),
        .help_toggle_i (help_toggle),
        .reveal_o      (reveal),
        .help_active_o (help_active)
    );

    logic [10:0] col_w, row_w, rev_w;
    logic        in_win;

    // Widened compares so X0+IMG_W cannot wrap.
    assign col_w  = {1'b0, col};
    assign row_w  = {2'b0, row};
    assign rev_w  = {{(11-REV_W){1'b0}}, reveal};
    assign in_win = video_on
                  && (col_w >= 11'(X0))
                  && (col_w < 11'(X0 + IMG_W))
                  && (row_w >= 11'(Y0))
                  && (row_w < 11'(Y0) + rev_w);

    logic [9:0]  img_x_q, img_x_d;
    logic [8:0]  img_y_q, img_y_d;
    logic        win_d1_q, vid_d1_q, win_d2_q, vid_d2_q;
    logic [11:0] bg_d1_q, bg_d2_q;
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        img_x_d = img_x_q;
        img_y_d = img_y_q;
        if (in_win) begin
            img_x_d = col - 10'(X0);
            img_y_d = row - 9'(Y0);
        end
    end

    always_comb begin
        rgb_d = bg_d2_q;
        if (!vid_d2_q) begin
            rgb_d = '0;
        end else if (win_d2_q && (img_clr != KEY_CLR)) begin
            rgb_d = img_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            img_x_q  <= '0;
            img_y_q  <= '0;
            win_d1_q <= 1'b0;
            vid_d1_q <= 1'b0;
            bg_d1_q  <= '0;
            win_d2_q <= 1'b0;
            vid_d2_q <= 1'b0;
            bg_d2_q  <= '0;
            rgb_q    <= '0;
        end else begin
            img_x_q  <= img_x_d;
            img_y_q  <= img_y_d;
            win_d1_q <= in_win;
            vid_d1_q <= video_on;
            bg_d1_q  <= bg_clr;
            win_d2_q <= win_d1_q;
            vid_d2_q <= vid_d1_q;
            bg_d2_q  <= bg_d1_q;
            rgb_q    <= rgb_d;
        end
    end

    assign img_x   = img_x_q;
    assign img_y   = img_y_q;
    assign vga_rgb = rgb_q;

endmodule

// File: tb/tb_help_overlay_render.sv
// Scoreboard bench for help_overlay_render with a frame-level reference
// model of the reveal behaviour and an external ROM model.
module tb_help_overlay_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  col;
    logic [8:0]  row;
    logic        video_on;
    logic        frame_tick;
    logic        help_toggle;
    logic [11:0] bg_clr;
    logic [9:0]  img_x;
    logic [8:0]  img_y;
    logic [11:0] img_clr;
    logic [11:0] vga_rgb;
    logic        help_active;

    help_overlay_render dut (
        .clk         (clk),
        .rst         (rst),
        .col         (col),
        .row         (row),
        .video_on    (video_on),
        .frame_tick  (frame_tick),
        .help_toggle (help_toggle),
        .bg_clr      (bg_clr),
        .img_x       (img_x),
        .img_y       (img_y),
        .img_clr     (img_clr),
        .vga_rgb     (vga_rgb),
        .help_active (help_active)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input int x, input int y);
        if (x == 5 && y == 5) return 12'h0F0;
        if (y == 5) return 12'hF00;
        return 12'((x * 37 + y * 101) ^ 'h5A5);
    endfunction

    always @(posedge clk) img_clr <= rom_f(int'(img_x), int'(img_y));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] rgb;
    } px_t;

    typedef struct {
        int         due;
        logic [9:0] x;
        logic [8:0] y;
        logic       ha;
        logic [7:0] rev;
    } st_t;

    px_t q3[$];
    st_t q1[$];

    int total = 0;
    int bad   = 0;

    // Reference model: overlay mode and revealed row count.
    localparam int M_HID = 0, M_OPEN = 1, M_SHOWN = 2, M_CLOSE = 3;
    int m_mode = M_HID;
    int m_rev  = 0;
    int m_x    = 0;
    int m_y    = 0;

    task automatic step(input int c_col, input int c_row, input bit vid,
                        input bit tick, input bit tog, input bit r,
                        input logic [11:0] bg);
        int          c;
        int          lx;
        int          ly;
        bit          win;
        logic [11:0] exp;
        @(posedge clk);
        #1;
        col         = c_col[9:0];
        row         = c_row[8:0];
        video_on    = vid;
        frame_tick  = tick;
        help_toggle = tog;
        rst         = r;
        bg_clr      = bg;
        c   = cyc;
        lx  = c_col - 180;
        ly  = c_row - 140;
        win = vid && c_col >= 180 && c_col < 460
                  && c_row >= 140 && c_row < 140 + m_rev;
        if (!vid) exp = 12'h000;
        else if (win && rom_f(lx, ly) != 12'h0F0) exp = rom_f(lx, ly);
        else exp = bg;
        if (r) begin
            exp = 12'h000;
            foreach (q3[i]) if (q3[i].due > c) q3[i].rgb = 12'h000;
        end
        q3.push_back('{due: c + 3, rgb: exp});
        if (r) begin
            m_x = 0;
            m_y = 0;
            m_mode = M_HID;
            m_rev = 0;
        end else begin
            if (win) begin
                m_x = lx;
                m_y = ly;
            end
            if (tog) begin
                if (m_mode == M_HID || m_mode == M_CLOSE) m_mode = M_OPEN;
                else m_mode = M_CLOSE;
            end else if (tick) begin
                if (m_mode == M_OPEN) begin
                    m_rev = (m_rev + 8 > 200) ? 200 : m_rev + 8;
                    if (m_rev == 200) m_mode = M_SHOWN;
                end else if (m_mode == M_CLOSE) begin
                    m_rev = (m_rev - 8 < 0) ? 0 : m_rev - 8;
                    if (m_rev == 0) m_mode = M_HID;
                end
            end
        end
        q1.push_back('{due: c + 1, x: m_x[9:0], y: m_y[8:0],
                       ha: (m_mode != M_HID), rev: m_rev[7:0]});
    endtask

    task automatic pix(input int c_col, input int c_row);
        step(c_col, c_row, 1'b1, 1'b0, 1'b0, 1'b0, 12'($urandom));
    endtask

    task automatic rnd_pix(input int n);
        for (int i = 0; i < n; i++)
            step(int'($urandom_range(170, 470)), int'($urandom_range(130, 350)),
                 ($urandom % 8) != 0, 1'b0, 1'b0, 1'b0, 12'($urandom));
    endtask

    task automatic tick();
        step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'($urandom));
    endtask

    task automatic toggle(input bit with_tick);
        step(0, 0, 1'b0, with_tick, 1'b1, 1'b0, 12'($urandom));
    endtask

    task automatic reset_cyc();
        step(int'($urandom_range(170, 470)), int'($urandom_range(130, 350)),
             1'b1, 1'b0, 1'b0, 1'b1, 12'($urandom));
    endtask

    // Monitor: compares outputs whose due cycle has arrived.
    initial begin
        px_t e3;
        st_t e1;
        forever begin
            @(posedge clk);
            #2;
            while (q3.size() > 0 && q3[0].due <= cyc) begin
                e3 = q3.pop_front();
                total++;
                if (e3.due != cyc || vga_rgb !== e3.rgb) begin
                    bad++;
                    $display("FAIL rgb cyc=%0d got=%h want=%h",
                             cyc, vga_rgb, e3.rgb);
                end
            end
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                e1 = q1.pop_front();
                total++;
                if (e1.due != cyc || img_x !== e1.x || img_y !== e1.y) begin
                    bad++;
                    $display("FAIL img_xy cyc=%0d got=%0d,%0d want=%0d,%0d",
                             cyc, img_x, img_y, e1.x, e1.y);
                end
                total++;
                if (help_active !== e1.ha) begin
                    bad++;
                    $display("FAIL help_active cyc=%0d got=%b want=%b",
                             cyc, help_active, e1.ha);
                end
                total++;
                if (dut.u_fsm.reveal_o !== e1.rev) begin
                    bad++;
                    $display("FAIL reveal cyc=%0d got=%0d want=%0d",
                             cyc, dut.u_fsm.reveal_o, e1.rev);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        col = '0;
        row = '0;
        video_on = 1'b0;
        frame_tick = 1'b0;
        help_toggle = 1'b0;
        bg_clr = '0;
        repeat (3) reset_cyc();

        // Hidden: pure background pass-through.
        rnd_pix(300);

        // Open fully: 25 ticks.
        toggle(1'b0);
        for (int t = 0; t < 25; t++) begin
            rnd_pix(20);
            tick();
        end
        rnd_pix(5);

        // Corners, edges and the colour key.
        pix(180, 140);
        pix(459, 339);
        pix(460, 339);
        pix(459, 340);
        pix(179, 140);
        pix(180, 139);
        pix(185, 145);
        pix(186, 145);
        rnd_pix(200);

        // Tick in SHOWN has no effect.
        tick();
        rnd_pix(10);

        // Close fully, then reopen to 96 and reverse on a coincident tick.
        toggle(1'b0);
        for (int t = 0; t < 26; t++) tick();
        toggle(1'b0);
        for (int t = 0; t < 12; t++) begin
            tick();
            rnd_pix(3);
        end
        toggle(1'b1);
        rnd_pix(20);
        tick();
        rnd_pix(20);
        for (int t = 0; t < 12; t++) begin
            tick();
            rnd_pix(3);
        end
        rnd_pix(50);

        // Open again and reset mid-frame while shown.
        toggle(1'b0);
        for (int t = 0; t < 25; t++) tick();
        rnd_pix(30);
        reset_cyc();
        rnd_pix(30);

        // Random mix of pixels, ticks, toggles and rare resets.
        for (int i = 0; i < 4000; i++) begin
            int k;
            k = int'($urandom % 1000);
            if (k < 3) reset_cyc();
            else if (k < 20) toggle(($urandom % 2) == 1);
            else if (k < 80) tick();
            else rnd_pix(1);
        end

        rnd_pix(0);
        repeat (6) @(posedge clk);
        #3;
        total++;
        if (q3.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d,%0d want=0,0", q3.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
